shutdown_sense_scanner: RTL and testbench



---
 rtl/shutdown_sense_scanner.sv | 179 +++++++++++++++++
 tb/tb_shutdown_sense_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shutdown_sense_scanner.sv
// Shared shutdown-sense line scanner: walks the external 8:1 mux across the
// populated boards, waits for the mux to settle, debounces the synchronized
// sense level and latches the first confirmed shutdown for the hardware manager.
module shutdown_sense_scanner #(
  parameter int unsigned SETTLE_CYCLES = 250,
  parameter int unsigned DEBOUNCE      = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       scan_en,
  input  logic [7:0] board_mask,
  input  logic       sense_in,
  input  logic       clear,
  output logic       mux_en,
  output logic [2:0] mux_sel,
  output logic       shutdown_sense,
  output logic [2:0] sense_num,
  output logic       scan_done
);

  localparam int unsigned TimerW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned HitW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [TimerW-1:0] SettleLast = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [HitW-1:0]   HitLast    = HitW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StFault} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [HitW-1:0]   hit_q, hit_d;
  logic              mux_en_q, mux_en_d;
  logic [2:0]        mux_sel_q, mux_sel_d;
  logic              latched_q, latched_d;
  logic [2:0]        num_q, num_d;
  logic              done_q, done_d;
  logic [1:0]        sync_q;
  logic              sense_s;
  logic              confirm;
  logic [2:0]        next_sel;

  // Lowest populated board, used when a scan starts from IDLE.
  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) res = 3'(i);
    end
    return res;
  endfunction

  // Next populated board strictly above cur, wrapping; a lone bit returns cur.
  function automatic logic [2:0] next_set(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] res;
    logic [2:0] idx;
    res = cur;
    for (int k = 8; k >= 1; k--) begin
      idx = cur + 3'(k);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

  assign sense_s  = sync_q[1];
  assign next_sel = next_set(board_mask, mux_sel_q);

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], sense_in};
  end

  // Next-state, mux control and fault latch decisions.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    hit_d     = hit_q;
    mux_en_d  = mux_en_q;
    mux_sel_d = mux_sel_q;
    latched_d = latched_q;
    num_d     = num_q;
    done_d    = 1'b0;
    confirm   = 1'b0;

    if (!scan_en) begin
      state_d   = StIdle;
      mux_en_d  = 1'b0;
      mux_sel_d = 3'd0;
      timer_d   = '0;
      hit_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (board_mask != 8'h00) begin
            mux_sel_d = lowest_set(board_mask);
            mux_en_d  = 1'b1;
            timer_d   = '0;
            hit_d     = '0;
            state_d   = StSettle;
          end else begin
            mux_en_d  = 1'b0;
            mux_sel_d = 3'd0;
          end
        end
        StSettle: begin
          if (timer_q == SettleLast) state_d = StSample;
          else                       timer_d = timer_q + TimerW'(1);
        end
        StSample: begin
          if (sense_s) begin
            if (hit_q == HitLast) begin
              confirm = 1'b1;
              state_d = StFault;
            end else begin
              hit_d = hit_q + HitW'(1);
            end
          end else begin
            hit_d   = '0;
            timer_d = '0;
            if (board_mask == 8'h00) begin
              state_d   = StIdle;
              mux_en_d  = 1'b0;
              mux_sel_d = 3'd0;
            end else begin
              mux_sel_d = next_sel;
              state_d   = StSettle;
              done_d    = (next_sel <= mux_sel_q);
            end
          end
        end
        StFault: begin
          if (clear) begin
            state_d   = StIdle;
            mux_en_d  = 1'b0;
            mux_sel_d = 3'd0;
          end
        end
      endcase
    end

    // A new confirmation beats a simultaneous clear; otherwise the first fault sticks.
    if (confirm && (clear || !latched_q)) begin
      latched_d = 1'b1;
      num_d     = mux_sel_q;
    end else if (clear) begin
      latched_d = 1'b0;
      num_d     = 3'd0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      hit_q     <= '0;
      mux_en_q  <= 1'b0;
      mux_sel_q <= 3'd0;
      latched_q <= 1'b0;
      num_q     <= 3'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      hit_q     <= hit_d;
      mux_en_q  <= mux_en_d;
      mux_sel_q <= mux_sel_d;
      latched_q <= latched_d;
      num_q     <= num_d;
      done_q    <= done_d;
    end
  end

  assign mux_en         = mux_en_q;
  assign mux_sel        = mux_sel_q;
  assign shutdown_sense = latched_q;
  assign sense_num      = num_q;
  assign scan_done      = done_q;

endmodule

// File: tb/tb_shutdown_sense_scanner.sv
// Bench for shutdown_sense_scanner: directed scenarios plus randomized traffic,
// every cycle compared against a dwell/run-length reference model.
module tb_shutdown_sense_scanner;

  localparam int S = 4;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       scan_en;
  logic [7:0] board_mask;
  logic       sense_in;
  logic       clear;
  logic       mux_en;
  logic [2:0] mux_sel;
  logic       shutdown_sense;
  logic [2:0] sense_num;
  logic       scan_done;

  int vectors = 0;
  int miscompares = 0;

  shutdown_sense_scanner #(
    .SETTLE_CYCLES(S),
    .DEBOUNCE     (D)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .scan_en       (scan_en),
    .board_mask    (board_mask),
    .sense_in      (sense_in),
    .clear         (clear),
    .mux_en        (mux_en),
    .mux_sel       (mux_sel),
    .shutdown_sense(shutdown_sense),
    .sense_num     (sense_num),
    .scan_done     (scan_done)
  );

  always #5 clk = ~clk;

  // Reference model: which board is selected, how long it has dwelt there, and
  // how many consecutive high samples have been seen on it.
  bit m_en = 0, m_active = 0, m_fault = 0, m_sd = 0, m_done = 0;
  int m_sel = 0, m_num = 0, m_age = 0, m_run = 0;
  bit p1 = 0, p2 = 0, s_now = 0, m_confirm = 0;
  int nxt = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_en = 0; m_active = 0; m_fault = 0; m_sd = 0; m_done = 0;
      m_sel = 0; m_num = 0; m_age = 0; m_run = 0; p1 = 0; p2 = 0;
    end else begin
      s_now = p2;
      p2 = p1;
      p1 = sense_in;
      m_done = 0;
      m_confirm = 0;
      if (!scan_en) begin
        m_active = 0; m_fault = 0; m_en = 0; m_sel = 0;
      end else if (m_fault) begin
        if (clear) begin
          m_fault = 0; m_en = 0; m_sel = 0;
        end
      end else if (!m_active) begin
        if (board_mask != 0) begin
          nxt = -1;
          for (int i = 0; i < 8; i++) if (nxt < 0 && board_mask[i]) nxt = i;
          m_sel = nxt; m_active = 1; m_en = 1; m_age = 0; m_run = 0;
        end else begin
          m_en = 0; m_sel = 0;
        end
      end else if (m_age < S) begin
        m_age++;
      end else if (s_now) begin
        if (m_run == D - 1) begin
          m_confirm = 1; m_fault = 1; m_active = 0;
        end else begin
          m_run++;
        end
      end else begin
        nxt = -1;
        for (int k = 1; k <= 8; k++) if (nxt < 0 && board_mask[(m_sel + k) % 8]) nxt = (m_sel + k) % 8;
        if (nxt < 0) begin
          m_active = 0; m_en = 0; m_sel = 0;
        end else begin
          m_done = (nxt <= m_sel);
          m_sel = nxt; m_age = 0; m_run = 0;
        end
      end
      if (m_confirm && (clear || !m_sd)) begin
        m_sd = 1; m_num = m_sel;
      end else if (clear) begin
        m_sd = 0; m_num = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".mux_en"},   {7'd0, mux_en},         {7'd0, m_en});
    check({tag, ".mux_sel"},  {5'd0, mux_sel},        8'(m_sel));
    check({tag, ".shutdown"}, {7'd0, shutdown_sense}, {7'd0, m_sd});
    check({tag, ".num"},      {5'd0, sense_num},      8'(m_num));
    check({tag, ".done"},     {7'd0, scan_done},      {7'd0, m_done});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Hold sense high only while the given board is selected, until a fault latches.
  task automatic fault_on(input string tag, input int board);
    int i;
    i = 0;
    while (!m_fault && i < 300) begin
      sense_in = (m_en && m_sel == board);
      cycle(tag);
      i++;
    end
    if (!m_fault) begin
      miscompares++;
      $error("FAIL %s: fault on board %0d not reached within bound", tag, board);
    end
  endtask

  initial begin
    resetn = 1'b1; scan_en = 1'b0; board_mask = 8'hFF; sense_in = 1'b0; clear = 1'b0;
    #2 resetn = 1'b0;
    @(negedge clk);
    check_outputs("reset");
    run("reset_hold", 2);
    resetn = 1'b1;

    // Clean scan of all eight boards.
    scan_en = 1'b1;
    run("clean_scan", 100);
    check("clean.no_fault", {7'd0, shutdown_sense}, 8'd0);

    // Fault on board 5, then clear and restart from board 0.
    fault_on("fault5", 5);
    run("fault5_hold", 6);
    check("fault5.sense", {7'd0, shutdown_sense}, 8'd1);
    check("fault5.num", {5'd0, sense_num}, 8'd5);
    check("fault5.frozen", {5'd0, mux_sel}, 8'd5);
    sense_in = 1'b0;
    clear = 1'b1;
    cycle("clear");
    clear = 1'b0;
    check("clear.sense", {7'd0, shutdown_sense}, 8'd0);
    check("clear.num", {5'd0, sense_num}, 8'd0);
    cycle("restart");
    check("restart.sel", {5'd0, mux_sel}, 8'd0);
    check("restart.en", {7'd0, mux_en}, 8'd1);
    run("restart_run", 10);

    // Two high samples on board 3: below the debounce count.
    for (int i = 0; i < 100 && !(m_active && m_sel == 3 && m_age == S - 2); i++) cycle("seek3");
    sense_in = 1'b1;
    run("short3", 2);
    sense_in = 1'b0;
    run("short3_after", 10);
    check("short3.no_fault", {7'd0, shutdown_sense}, 8'd0);

    // Sparse mask, then empty mask.
    board_mask = 8'h24;
    run("mask24", 45);
    board_mask = 8'h00;
    run("mask00", 20);
    check("mask00.en", {7'd0, mux_en}, 8'd0);

    // Fault on board 2, then drop scan_en mid-SETTLE with the fault latched.
    board_mask = 8'hFF;
    fault_on("fault2", 2);
    sense_in = 1'b0;
    scan_en = 1'b0;
    cycle("drop_fault");
    scan_en = 1'b1;
    run("rescan", 2);
    scan_en = 1'b0;
    cycle("drop_settle");
    check("drop.en", {7'd0, mux_en}, 8'd0);
    check("drop.sel", {5'd0, mux_sel}, 8'd0);
    check("drop.sense", {7'd0, shutdown_sense}, 8'd1);
    check("drop.num", {5'd0, sense_num}, 8'd2);

    // Asynchronous reset while in FAULT.
    scan_en = 1'b1;
    clear = 1'b1;
    cycle("clear2");
    clear = 1'b0;
    fault_on("fault1", 1);
    sense_in = 1'b0;
    resetn = 1'b0;
    #1;
    check_outputs("async_reset");
    check("async.sense", {7'd0, shutdown_sense}, 8'd0);
    @(negedge clk);
    resetn = 1'b1;
    run("post_reset", 3);
    check("post_reset.sel", {5'd0, mux_sel}, 8'd0);
    check("post_reset.en", {7'd0, mux_en}, 8'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) sense_in = ~sense_in;
      clear = ($urandom_range(39) == 0);
      scan_en = ($urandom_range(149) != 0);
      if ($urandom_range(199) == 0) begin
        case ($urandom_range(3))
          0: board_mask = 8'h00;
          1: board_mask = 8'(1 << $urandom_range(7));
          default: board_mask = 8'($urandom);
        endcase
      end
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
